display_scan_mux: RTL and testbench

- Time-multiplexed scan driver for the 4-digit 7-segment clock display. Sits directly upstream of the anode driver.
- Cycles a one-hot digit enable at a fixed refresh rate; the anode driver consumes this as its `enable_input`.
- Selects the active digit's BCD value and drives the matching active-low segment cathodes and decimal point, aligned to that enable.
- Supports leading-zero blanking and per-digit blinking, used for time-set and alarm-set modes.

---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/display_scan_mux.sv | 107 ++++++++++
 tb/tb_display_scan_mux.sv | 137 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: digit count, segment
// bit positions and the active-low glyph patterns.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment bit order within a 7-bit pattern {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes are blank.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit 7-segment display with
// leading-zero blanking and per-digit blink.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           digits_bcd,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  blank_lead,
    output logic [NUM_DIGITS-1:0] enable_output,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  blink_phase
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         idx;
    logic [1:0]         idx_next;
    logic               scan_tc;
    logic               blink_tc;
    logic               phase_next;
    logic [3:0]         sel_bcd;
    logic [6:0]         dec_seg;
    logic               lead_blank;
    logic               blink_blank;
    logic [6:0]         seg_next;
    logic               dp_next;

    assign scan_tc    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign blink_tc   = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign idx_next   = scan_tc ? idx + 2'd1 : idx;
    assign phase_next = blink_tc ? ~blink_phase : blink_phase;

    // Everything below is keyed on idx_next so seg/dp land on the same edge
    // as the enable they belong to.
    always_comb begin
        sel_bcd    = digits_bcd[3:0];
        lead_blank = 1'b0;
        case (idx_next)
            2'd0: begin
                sel_bcd    = digits_bcd[3:0];
                lead_blank = 1'b0;
            end
            2'd1: begin
                sel_bcd    = digits_bcd[7:4];
                lead_blank = (digits_bcd[15:4] == 12'h000);
            end
            2'd2: begin
                sel_bcd    = digits_bcd[11:8];
                lead_blank = (digits_bcd[15:8] == 8'h00);
            end
            default: begin
                sel_bcd    = digits_bcd[15:12];
                lead_blank = (digits_bcd[15:12] == 4'h0);
            end
        endcase
        lead_blank = lead_blank & blank_lead;
    end

    bcd_to_seg u_dec (
        .bcd (sel_bcd),
        .seg (dec_seg)
    );

    // Blink blanking overrides leading-zero blanking, which overrides decode.
    always_comb begin
        blink_blank = phase_next & blink_mask[idx_next];
        seg_next    = dec_seg;
        dp_next     = ~dp_in[idx_next];
        if (blink_blank) begin
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end else if (lead_blank) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt      <= '0;
            blink_cnt     <= '0;
            idx           <= 2'd0;
            blink_phase   <= 1'b0;
            enable_output <= 4'b0001;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
        end else begin
            scan_cnt      <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
            blink_cnt     <= blink_tc ? '0 : blink_cnt + BLINK_W'(1);
            idx           <= idx_next;
            blink_phase   <= phase_next;
            enable_output <= 4'b0001 << idx_next;
            seg           <= seg_next;
            dp            <= dp_next;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with short scan and blink dividers.
module tb_display_scan_mux;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        blank_lead;
    logic [3:0]  enable_output;
    logic [6:0]  seg;
    logic        dp;
    logic        blink_phase;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // edges since reset released

    display_scan_mux #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digits_bcd    (digits_bcd),
        .dp_in         (dp_in),
        .blink_mask    (blink_mask),
        .blank_lead    (blank_lead),
        .enable_output (enable_output),
        .seg           (seg),
        .dp            (dp),
        .blink_phase   (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        chk("rst_enable", 32'(enable_output), 32'h1);
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_phase", 32'(blink_phase), 32'h0);
        reset = 1'b0;
    endtask

    // segs = {seg3,seg2,seg1,seg0}; dpn = expected active-low dp per digit
    task automatic scan_check(input int n, input logic [27:0] segs,
                              input logic [3:0] dpn, input logic [3:0] bmask);
        for (int i = 0; i < n; i++) begin
            int         di;
            logic       ph;
            logic       blk;
            logic [6:0] exp_seg;
            logic       exp_dp;
            step();
            di      = (k / 4) % 4;
            ph      = ((k / 16) % 2) == 1;
            blk     = ph && bmask[di];
            exp_seg = blk ? 7'h7f : segs[di*7 +: 7];
            exp_dp  = blk ? 1'b1 : dpn[di];
            chk("enable", 32'(enable_output), 32'(4'b0001 << di));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("dp", 32'(dp), 32'(exp_dp));
            chk("phase", 32'(blink_phase), 32'(ph));
        end
    endtask

    initial begin
        reset      = 1'b1;
        digits_bcd = 16'h1234;
        dp_in      = 4'b0000;
        blink_mask = 4'b0000;
        blank_lead = 1'b0;

        // Plain decode of 1234, full rotation plus wrap
        do_reset();
        scan_check(17, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, 4'b0000);

        // Leading-zero blanking
        digits_bcd = 16'h0012;
        blank_lead = 1'b1;
        do_reset();
        scan_check(16, {7'h7f, 7'h7f, 7'b1111001, 7'b0100100}, 4'b1111, 4'b0000);

        digits_bcd = 16'h0000;
        do_reset();
        scan_check(16, {7'h7f, 7'h7f, 7'h7f, 7'b1000000}, 4'b1111, 4'b0000);

        // Non-BCD nibbles blank; also covers 7, 9
        digits_bcd = 16'h7A9B;
        blank_lead = 1'b0;
        do_reset();
        scan_check(16, {7'b1111000, 7'h7f, 7'b0010000, 7'h7f}, 4'b1111, 4'b0000);

        // Blink with decimal point on digit 2
        digits_bcd = 16'h1234;
        dp_in      = 4'b0100;
        blink_mask = 4'b0011;
        do_reset();
        scan_check(48, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011, 4'b0011);

        // Mask change mid-phase: no effect on blink counter
        blink_mask = 4'b1100;
        scan_check(16, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011, 4'b1100);

        // Reset mid-scan (idx=2, phase=1), then rescan from scratch
        blink_mask = 4'b0011;
        do_reset();
        scan_check(25, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011, 4'b0011);
        do_reset();
        scan_check(20, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011, 4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
